fp16_to_int_converter: RTL
==========================

FP16_TO_INT_CONVERTER -- requirements
Module: fp16_to_int_converter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand width; only 16 (IEEE-754 binary16 in, signed int16 out) is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data holds an FP16 operand.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE and never while reset is high.
REQ-006 in_data  input  16  FP16 operand {sign[15], exp[14:10], man[9:0]}.
REQ-007 out_valid  output  1  out_data and out_flags valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_data  output  16  signed two's-complement integer result.
REQ-010 out_flags  output  3  [2] nan, [1] overflow, [0] inexact.

Function
REQ-011 FSM states: IDLE, SHIFT, ROUND, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-012 Accept occurs on an edge with IDLE & in_valid; the operand is captured and classified on that edge.
REQ-013 Special classes go IDLE->DONE directly, so out_valid is high in the cycle after the accept edge (latency 1).
REQ-014 exp==31, man!=0 (NaN): out_data=0, flags=100.
REQ-015 exp==31, man==0 (Inf): out_data=+32767 or -32768 by sign, flags=010.
REQ-016 exp==0: out_data=0; flags=001 if man!=0 (subnormal), else 000; -0 gives 0.
REQ-017 Normal operand, E=exp-15: E<-1 -> special path, out_data=0, flags=001.
REQ-018 E>=16, or E==15 except 0xF800 -> special path, saturate to +32767/-32768 by sign, flags=010.
REQ-019 0xF800 -> special path, out_data=-32768 (0x8000), flags=000.
REQ-020 -1<=E<=14 -> SHIFT path with 27-bit register R (int R[26:11], frac R[10:0]), loaded with R={15'b0,1,man,1'b0} for E>=0 and R={16'b0,1,man} for E==-1; count=max(E,0).
REQ-021 SHIFT: if count!=0, R<<=1 and count-=1 per cycle; if count==0, go to ROUND.
REQ-022 ROUND: round half to even with lsb=R[11], guard=R[10], sticky=|R[9:0].
REQ-023 ROUND: mag=R[26:11]+(guard&(sticky|lsb)).
REQ-024 ROUND: out_data=sign?-mag:mag (0 never negative); inexact=guard|sticky; nan=overflow=0; go to DONE.
REQ-025 Normal-path latency: out_valid rises after edge count+2 counted from the accept edge (state after the accept edge is SHIFT).
REQ-026 DONE: out_data/out_flags held stable while out_ready low; DONE & out_ready -> IDLE on that edge.
REQ-027 Minimum one-cycle bubble between results, since in_ready is low in DONE.
REQ-028 in_data changes while not in IDLE are ignored.
REQ-029 out_data and out_flags are registered, with no combinational path from in_data to outputs.

Reset
REQ-030 reset high on an edge -> state=IDLE, out_data=0, out_flags=0, count=0, R=0, regardless of current state (including mid-SHIFT or DONE).
REQ-031 While reset is high: out_valid=0, in_ready=0.
REQ-032 The first cycle after reset deasserts: in_ready=1; any in-flight operand is discarded with no result produced.

Verification
REQ-033 0x4500 (5.0), out_ready=1 -> out_data=5, flags=000, out_valid after edge 4 from accept (E=2).
REQ-034 Rounding set:
- 0xC100 -> -2, flags 001
- 0x3E00 -> 2, flags 001
- 0x3800 -> 0, flags 001
- 0x3A00 -> 1, flags 001
- 0x3C00 -> 1, flags 000
REQ-035 Specials, each latency 1:
- 0x7C00 -> 32767, flags 010
- 0xFC00 -> -32768, flags 010
- 0xFE00 -> 0, flags 100
- 0xF800 -> -32768, flags 000
- 0x7800 -> 32767, flags 010
- 0x8000 -> 0, flags 000
- 0x0001 -> 0, flags 001
REQ-036 Backpressure: 0x7000 with out_ready=0 for 5 cycles after out_valid -> out_data=8192, flags stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-037 Reset mid-SHIFT: accept 0x7000, assert reset 3 cycles later for 1 cycle -> outputs zero, out_valid never rises for that operand, in_ready=1 after release.
REQ-038 Back-to-back: in_valid held high with out_ready=1 streaming 0x4400, 0xC200 -> results 4, -3 in order, one bubble each.

Source files
------------

// File: rtl/fp16_to_int_converter.sv
// Converts an IEEE-754 binary16 operand to a saturating signed 16-bit integer
// using round-half-to-even, with nan/overflow/inexact flags and valid/ready handshakes.
module fp16_to_int_converter #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_flags
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [26:0]           r_q, r_d;
  logic [3:0]            count_q, count_d;
  logic                  sign_q, sign_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]            out_flags_q, out_flags_d;

  logic       in_sign;
  logic [4:0] in_exp;
  logic [9:0] in_man;

  assign in_sign = in_data[15];
  assign in_exp  = in_data[14:10];
  assign in_man  = in_data[9:0];

  // Operand classification: everything that bypasses the shifter.
  logic                  is_special;
  logic [DATA_WIDTH-1:0] spec_data;
  logic [2:0]            spec_flags;
  logic [DATA_WIDTH-1:0] sat_data;

  assign sat_data = in_sign ? 16'h8000 : 16'h7FFF;

  always_comb begin
    is_special = 1'b1;
    spec_data  = '0;
    spec_flags = 3'b000;
    if (in_exp == 5'd31) begin
      if (in_man != 10'd0) begin
        spec_flags = 3'b100;
      end else begin
        spec_data  = sat_data;
        spec_flags = 3'b010;
      end
    end else if (in_exp == 5'd0) begin
      spec_flags = {2'b00, |in_man};
    end else if (in_exp < 5'd14) begin
      // Magnitude below 0.5 always rounds to zero.
      spec_flags = 3'b001;
    end else if (in_exp == 5'd30) begin
      if (in_data == 16'hF800) begin
        spec_data  = 16'h8000;
        spec_flags = 3'b000;
      end else begin
        spec_data  = sat_data;
        spec_flags = 3'b010;
      end
    end else begin
      is_special = 1'b0;
    end
  end

  // Rounding of the shifted fixed-point value.
  logic                  rnd_lsb, rnd_guard, rnd_sticky;
  logic [15:0]           rnd_mag;
  logic [DATA_WIDTH-1:0] rnd_data;

  assign rnd_lsb    = r_q[11];
  assign rnd_guard  = r_q[10];
  assign rnd_sticky = |r_q[9:0];
  assign rnd_mag    = r_q[26:11] + {15'd0, rnd_guard & (rnd_sticky | rnd_lsb)};
  assign rnd_data   = sign_q ? (~rnd_mag + 16'd1) : rnd_mag;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    count_d     = count_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_sign;
          if (is_special) begin
            out_data_d  = spec_data;
            out_flags_d = spec_flags;
            state_d     = StDone;
          end else begin
            if (in_exp == 5'd14) begin
              r_d     = {16'd0, 1'b1, in_man};
              count_d = 4'd0;
            end else begin
              r_d     = {15'd0, 1'b1, in_man, 1'b0};
              count_d = 4'(in_exp - 5'd15);
            end
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (count_q != 4'd0) begin
          r_d     = {r_q[25:0], 1'b0};
          count_d = count_q - 4'd1;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        out_data_d  = rnd_data;
        out_flags_d = {2'b00, rnd_guard | rnd_sticky};
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      r_q         <= '0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign in_ready  = (state_q == StIdle) & ~reset;
  assign out_valid = (state_q == StDone) & ~reset;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule
